// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the 16-bit SRAM memory controller.
package mem_ctrl_pkg;

  localparam int unsigned DATA_MEM_BASE = 1024;
  localparam int unsigned SRAM_AW       = 18;
  localparam int unsigned DATA_W        = 32;
  localparam int unsigned HALF_W        = 16;
  localparam int unsigned CNT_W         = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } mem_state_e;

endpackage

// File: rtl/sram_phase_counter.sv
// Phase counter shared by the LO and HI halfword phases; wraps to 0 after last.
module sram_phase_counter
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned PHASE_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  assign last = (cnt == CNT_W'(PHASE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sram_mem_controller.sv
// Splits a 32-bit MEM-stage load/store into two 16-bit SRAM accesses, low half first.
// Optional stall_cycles output when SRAM_STALL_COUNT_EN is defined.
module sram_mem_controller
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'(DATA_MEM_BASE),
  parameter int unsigned PHASE_CYCLES = 3,
  parameter int unsigned SRAM_AW      = mem_ctrl_pkg::SRAM_AW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic [DATA_W-1:0]    address,
  input  logic [DATA_W-1:0]    write_data,
  output logic [DATA_W-1:0]    read_data,
  output logic                 ready,
  inout  wire  [HALF_W-1:0]    SRAM_DQ,
  output logic [SRAM_AW-1:0]   SRAM_ADDR,
  output logic                 SRAM_WE_N,
  output logic                 SRAM_UB_N,
  output logic                 SRAM_LB_N,
  output logic                 SRAM_CE_N,
  output logic                 SRAM_OE_N
`ifdef SRAM_STALL_COUNT_EN
  ,
  output logic [DATA_W-1:0]    stall_cycles
`endif
);

  mem_state_e          state;
  mem_state_e          state_next;
  logic                is_wr;
  logic [CNT_W-1:0]    cnt;
  logic                last;
  logic                cnt_en;
  logic                cnt_clr;
  logic                dq_oe;
  logic [HALF_W-1:0]   dq_out;
  logic [DATA_W-1:0]   off;
  logic [SRAM_AW-2:0]  word;
  logic                unused_off;

  // Byte offset wraps mod 2^32; the byte-in-word bits are ignored.
  assign off        = address - BASE_ADDR;
  assign word       = off[SRAM_AW:2];
  assign unused_off = ^{off[DATA_W-1:SRAM_AW+1], off[1:0], cnt};

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_DQ   = dq_oe ? dq_out : {HALF_W{1'bz}};

  sram_phase_counter #(
    .PHASE_CYCLES (PHASE_CYCLES)
  ) u_phase_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .cnt  (cnt),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // WE_N rises on the last cycle of a phase so address/data stay stable across it.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    SRAM_WE_N  = 1'b1;
    SRAM_ADDR  = '0;
    dq_oe      = 1'b0;
    dq_out     = '0;
    cnt_en     = 1'b0;
    cnt_clr    = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        ready   = ~(rd_en | wr_en);
        if (rd_en | wr_en) begin
          state_next = LO;
        end
      end
      LO: begin
        cnt_en    = 1'b1;
        SRAM_ADDR = {word, 1'b0};
        if (is_wr) begin
          dq_oe     = 1'b1;
          dq_out    = write_data[HALF_W-1:0];
          SRAM_WE_N = last;
        end
        if (last) begin
          state_next = HI;
        end
      end
      HI: begin
        cnt_en    = 1'b1;
        SRAM_ADDR = {word, 1'b1};
        if (is_wr) begin
          dq_oe     = 1'b1;
          dq_out    = write_data[DATA_W-1:HALF_W];
          SRAM_WE_N = last;
        end
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        cnt_clr    = 1'b1;
        ready      = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operation type latched at acceptance; a simultaneous read+write becomes a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_wr     <= 1'b0;
      read_data <= '0;
    end else begin
      if (state == IDLE && (rd_en || wr_en)) begin
        is_wr <= wr_en;
      end
      if (!is_wr && last) begin
        if (state == LO) begin
          read_data[HALF_W-1:0] <= SRAM_DQ;
        end else if (state == HI) begin
          read_data[DATA_W-1:HALF_W] <= SRAM_DQ;
        end
      end
    end
  end

`ifdef SRAM_STALL_COUNT_EN
  // Saturating count of frozen-pipeline cycles for CPI measurement.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (!ready && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + DATA_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_sram_mem_controller.sv
// Scoreboard bench for sram_mem_controller with a behavioural 16-bit SRAM model.
module tb_sram_mem_controller;

  localparam int EXP_STALL = 7;
  localparam int SEL_READY = 0;
  localparam int SEL_WEN   = 1;
  localparam int SEL_ADDR  = 2;
  localparam int SEL_RD    = 3;
  localparam int SEL_HW    = 4;
  localparam int SEL_STALL = 5;
  localparam int SEL_QSIZE = 6;

  typedef struct {
    logic [31:0] rd;
    int          we_low;
  } exp_t;

  typedef struct {
    string       name;
    int          sel;
    int          idx;
    logic [31:0] exp;
  } probe_t;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic        sram_ub_n;
  logic        sram_lb_n;
  logic        sram_ce_n;
  logic        sram_oe_n;
`ifdef SRAM_STALL_COUNT_EN
  logic [31:0] stall_cycles;
`endif

  logic        tb_read;
  logic [15:0] hw [64];
  exp_t        exp_q[$];
  probe_t      probe_q[$];
  int          n_cmp;
  int          n_fail;
  int          stall_n;
  int          we_low;

  sram_mem_controller #(
    .BASE_ADDR    (32'd1024),
    .PHASE_CYCLES (3),
    .SRAM_AW      (18)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .SRAM_DQ    (sram_dq),
    .SRAM_ADDR  (sram_addr),
    .SRAM_WE_N  (sram_we_n),
    .SRAM_UB_N  (sram_ub_n),
    .SRAM_LB_N  (sram_lb_n),
    .SRAM_CE_N  (sram_ce_n),
    .SRAM_OE_N  (sram_oe_n)
`ifdef SRAM_STALL_COUNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: drives reads when the bench expects a load, stores while WE_N is low.
  assign sram_dq = (tb_read && sram_we_n) ? hw[sram_addr[5:0]] : 16'hzzzz;

  always @(negedge clk) begin
    if (rst) begin
      hw[2] <= 16'hBEEF;
      hw[3] <= 16'hDEAD;
    end else if (!sram_we_n) begin
      hw[sram_addr[5:0]] <= sram_dq;
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  // Monitor: measures each stall, checks it at DONE against the queued expectation.
  always @(negedge clk) begin
    probe_t      p;
    exp_t        e;
    logic [31:0] act;
    if (rst) begin
      stall_n = 0;
      we_low  = 0;
    end else if (!ready) begin
      stall_n++;
      if (!sram_we_n) we_low++;
    end else if (stall_n > 0) begin
      if (exp_q.size() == 0) begin
        cmp("unexpected_done", 32'(stall_n), 32'd0);
      end else begin
        e = exp_q.pop_front();
        cmp("stall_len", 32'(stall_n), 32'(EXP_STALL));
        cmp("we_low_cycles", 32'(we_low), 32'(e.we_low));
        cmp("read_data_done", read_data, e.rd);
      end
      stall_n = 0;
      we_low  = 0;
    end
    while (probe_q.size() > 0) begin
      p   = probe_q.pop_front();
      act = '0;
      case (p.sel)
        SEL_READY: act = 32'(ready);
        SEL_WEN:   act = 32'(sram_we_n);
        SEL_ADDR:  act = 32'(sram_addr);
        SEL_RD:    act = read_data;
        SEL_HW:    act = 32'(hw[p.idx]);
`ifdef SRAM_STALL_COUNT_EN
        SEL_STALL: act = stall_cycles;
`endif
        SEL_QSIZE: act = 32'(exp_q.size());
        default:   act = 32'hFFFF_FFFF;
      endcase
      cmp(p.name, act, p.exp);
    end
  end

  task automatic probe(input string nm, input int sel, input int idx, input logic [31:0] exp);
    probe_t p;
    p.name = nm;
    p.sel  = sel;
    p.idx  = idx;
    p.exp  = exp;
    probe_q.push_back(p);
  endtask

  // Issues one request and holds it until ready is seen high (the DONE cycle).
  task automatic access(input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, input int exp_we);
    exp_t e;
    bit   ok;
    e.rd     = exp_rd;
    e.we_low = exp_we;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    tb_read    = r & ~w;
    wr_en      = w;
    rd_en      = r;
    address    = a;
    write_data = d;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) probe("timeout_ready", SEL_READY, 0, 32'd1);
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    for (int i = 1; i < n; i++) @(posedge clk);
  endtask

  initial begin
    rst        = 1'b1;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    address    = '0;
    write_data = '0;
    tb_read    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    probe("rst_ready", SEL_READY, 0, 32'd1);
    probe("rst_we_n", SEL_WEN, 0, 32'd1);
    probe("rst_addr", SEL_ADDR, 0, 32'd0);
    probe("rst_read_data", SEL_RD, 0, 32'd0);
`ifdef SRAM_STALL_COUNT_EN
    probe("rst_stall_cycles", SEL_STALL, 0, 32'd0);
`endif

    access(1'b1, 1'b0, 32'd1024, 32'h1234_5678, 32'h0, 4);
    idle(2);
    probe("store_hw0", SEL_HW, 0, 32'h5678);
    probe("store_hw1", SEL_HW, 1, 32'h1234);

    access(1'b0, 1'b1, 32'd1024, 32'h0, 32'h1234_5678, 0);
    idle(3);
    probe("read_data_hold", SEL_RD, 0, 32'h1234_5678);
    access(1'b0, 1'b1, 32'd1028, 32'h0, 32'hDEAD_BEEF, 0);
    idle(1);
`ifdef SRAM_STALL_COUNT_EN
    probe("stall_cycles_21", SEL_STALL, 0, 32'd21);
`endif

    // Back-to-back: the load is presented right after the store's DONE edge.
    access(1'b1, 1'b0, 32'd1036, 32'h0BAD_C0DE, 32'hDEAD_BEEF, 4);
    access(1'b0, 1'b1, 32'd1036, 32'h0, 32'h0BAD_C0DE, 0);
    idle(2);
    probe("b2b_hw6", SEL_HW, 6, 32'hC0DE);
    probe("b2b_hw7", SEL_HW, 7, 32'h0BAD);

    access(1'b1, 1'b1, 32'd1032, 32'hCAFE_F00D, 32'h0BAD_C0DE, 4);
    idle(2);
    probe("both_hw4", SEL_HW, 4, 32'hF00D);
    probe("both_hw5", SEL_HW, 5, 32'hCAFE);
    probe("both_read_data", SEL_RD, 0, 32'h0BAD_C0DE);

    // Address below base wraps to the top of the SRAM (halfwords 0x3FFFE/0x3FFFF).
    access(1'b1, 1'b0, 32'd1020, 32'h1111_2222, 32'h0BAD_C0DE, 4);
    idle(2);
    probe("wrap_hw62", SEL_HW, 62, 32'h2222);
    probe("wrap_hw63", SEL_HW, 63, 32'h1111);
    access(1'b0, 1'b1, 32'd1020, 32'h0, 32'h1111_2222, 0);
    idle(2);

    // Reset during the HI phase of a store.
    @(posedge clk);
    #1;
    tb_read    = 1'b0;
    wr_en      = 1'b1;
    address    = 32'd1040;
    write_data = 32'h55AA_33CC;
    repeat (5) @(posedge clk);
    #1;
    probe("mid_hi_ready", SEL_READY, 0, 32'd0);
    rst   = 1'b1;
    wr_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    probe("midrst_ready", SEL_READY, 0, 32'd1);
    probe("midrst_we_n", SEL_WEN, 0, 32'd1);
    probe("midrst_addr", SEL_ADDR, 0, 32'd0);
    probe("midrst_read_data", SEL_RD, 0, 32'd0);
`ifdef SRAM_STALL_COUNT_EN
    probe("midrst_stall_cycles", SEL_STALL, 0, 32'd0);
`endif
    idle(2);
    probe("pending_expect", SEL_QSIZE, 0, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
- Sequences the external 16-bit SRAM on behalf of the MEM stage.
- Converts one 32-bit load or store into two halfword SRAM accesses, low half first.
- Holds `ready` low for the whole access so the top level can freeze the pipeline through the same freeze path the hazard unit drives.
- Sits between the MEM-stage register outputs and the board SRAM pins.

Parameters:
- BASE_ADDR, 1024: data-memory base; the SRAM byte offset is address - BASE_ADDR, computed mod 2^32.
- PHASE_CYCLES, 3: cycles per halfword phase. Legal range 2..15.
- SRAM_AW, 18: SRAM halfword address width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  store request; must be held stable until ready=1.
- rd_en  in  1  load request; must be held stable until ready=1.
- address  in  32  byte address of the access.
- write_data  in  32  store data.
- read_data  out  32  load result; registered.
- ready  out  1  0 = freeze pipeline.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  out  18  SRAM halfword address.
- SRAM_WE_N  out  1  active-low write strobe.
- SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  out  1 each  tied 0.

Behaviour:
- States: IDLE, LO, HI, DONE.
  - Encoding lives in the package.
  - A 4-bit phase counter `cnt` counts 0..PHASE_CYCLES-1.
- Reset values:
  - state=IDLE, cnt=0, read_data=0.
  - SRAM_WE_N=1, SRAM_DQ=Z, SRAM_ADDR=0.
  - ready=1 while no request is present.
- `ready` is combinational:
  - 1 in IDLE when rd_en=wr_en=0.
  - 1 in DONE.
  - 0 otherwise, including IDLE with a request present.
- Address mapping:
  - off = address - BASE_ADDR.
  - word = off[SRAM_AW:2].
  - LO phase uses SRAM_ADDR = {word,1'b0}; HI phase uses {word,1'b1}.
  - off[1:0] is ignored.
  - address < BASE_ADDR wraps; it is not an error.
- Transitions:
  - IDLE → LO on (rd_en|wr_en); the operation type is latched at this edge.
  - LO → HI when cnt==PHASE_CYCLES-1; cnt then clears.
  - HI → DONE when cnt==PHASE_CYCLES-1.
  - DONE → IDLE unconditionally. The pipeline advances at the DONE edge, so a following memory instruction is accepted fresh in IDLE.
- Latency: ready is low for 1+2*PHASE_CYCLES cycles and high on the next (DONE) cycle. Default: 7 low, high on cycle 8.
- Write:
  - SRAM_DQ drives write_data[15:0] in LO and write_data[31:16] in HI.
  - SRAM_WE_N=0 for cnt<PHASE_CYCLES-1 and 1 on the last cycle of each phase, so address and data are stable across the WE rising edge.
  - DQ is Z in IDLE and DONE.
- Read:
  - SRAM_WE_N=1 and DQ=Z throughout.
  - read_data[15:0] captures SRAM_DQ on the last LO cycle; read_data[31:16] on the last HI cycle.
  - read_data is valid in DONE and holds until the next read completes. Writes never alter it.
- rd_en & wr_en together: the write wins and the read is dropped. This is a protocol violation but has defined behaviour.
- Requests changing mid-access are ignored; the latched type and the live address/write_data are used. The spec requires the inputs to be held stable.
- rst mid-access: next cycle is IDLE, WE_N=1, DQ=Z, read_data=0. The SRAM word may be half-written; that is acceptable.

Optional Feature:
- Macro SRAM_STALL_COUNT_EN.
- Defined:
  - Adds output `stall_cycles[31:0]`, which increments every cycle ready=0.
  - It saturates at 0xFFFFFFFF and is cleared by rst.
  - Used for CPI measurement.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package `mem_ctrl_pkg`:
  - state enum (IDLE/LO/HI/DONE).
  - DATA_MEM_BASE=1024.
  - SRAM_AW=18.
- One sub-module `sram_phase_counter`:
  - Inputs: clk, rst, clr, en.
  - Outputs: cnt and last (cnt==PHASE_CYCLES-1).
  - Reused by the top FSM for both phases.

Test Plan:
- Store 0x12345678 to address 1024 (PHASE_CYCLES=3) → SRAM model hw[0]=0x5678, hw[1]=0x1234; ready=0 for exactly 7 cycles, then 1 for one cycle; WE_N low for 2 cycles in each phase.
- Load from address 1024 after the above → read_data=0x12345678 in DONE; the next load from 1028 (model hw[2]=0xBEEF, hw[3]=0xDEAD) → 0xDEADBEEF; read_data holds between the two loads.
- Back-to-back store then load with requests re-asserted the cycle after DONE → two full 7-cycle stalls; no request lost or merged.
- rd_en=wr_en=1 at address 1032, write_data=0xCAFEF00D → hw[4]=0xF00D, hw[5]=0xCAFE; read_data unchanged.
- Assert rst in HI of a store → next cycle IDLE, ready=1 (no request), WE_N=1, DQ=Z, read_data=0.
- With SRAM_STALL_COUNT_EN: three accesses → stall_cycles=21; a reset returns it to 0.
